// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - signed 16-bit product to sign + 5-digit BCD (double-dabble)
module product_bcd_converter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Product,
    output logic        Busy,
    output logic        Done,
    output logic        Neg,
    output logic [19:0] Digits,
    output logic [2:0]  Sig_Count
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t      state;
    logic [15:0] mag;
    logic [19:0] bcd;
    logic [3:0]  cnt;
    logic        neg_int;

    logic [19:0] bcd_adj;
    logic [19:0] bcd_shift;
    logic [2:0]  sig_next;
    logic [3:0]  digit;

    always_comb begin
        bcd_adj = '0;
        digit   = '0;
        for (int i = 0; i < 5; i++) begin
            digit = bcd[4*i +: 4];
            bcd_adj[4*i +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
        bcd_shift = {bcd_adj[18:0], mag[15]};
    end

    // Sig_Count is taken from the fully shifted value so it matches what lands in Digits.
    always_comb begin
        sig_next = 3'd1;
        if (bcd_shift[19:16] != 4'd0)
            sig_next = 3'd5;
        else if (bcd_shift[15:12] != 4'd0)
            sig_next = 3'd4;
        else if (bcd_shift[11:8] != 4'd0)
            sig_next = 3'd3;
        else if (bcd_shift[7:4] != 4'd0)
            sig_next = 3'd2;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            mag       <= '0;
            bcd       <= '0;
            neg_int   <= 1'b0;
            Digits    <= '0;
            Neg       <= 1'b0;
            Sig_Count <= 3'd1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        neg_int <= Product[15];
                        // Two's-complement negate; 0x8000 maps to 0x8000 as unsigned 32768.
                        mag     <= Product[15] ? (~Product + 16'd1) : Product;
                        bcd     <= '0;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bcd <= bcd_shift;
                    mag <= {mag[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        Digits    <= bcd_shift;
                        Neg       <= neg_int;
                        Sig_Count <= sig_next;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
